// File: rtl/mem_controller_pkg.sv
// mem_controller_pkg: shared defaults, FSM state and op encodings for mem_controller
// CLEAR exists only with MEM_CONTROLLER_INIT_CLEAR_EN defined
package mem_controller_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 32;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
    ,
    CLEAR
`endif
  } state_t;
endpackage

// File: rtl/mem_controller.sv
// mem_controller: request FSM in front of a single-port registered-read memory
// MEM_CONTROLLER_INIT_CLEAR_EN adds a post-reset zero fill of every address
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              p_Clock,
  input  logic              p_Resetn,
  input  logic              p_ReqValid,
  output logic              p_ReqReady,
  input  logic              p_ReqWrite,
  input  logic [ADDR_W-1:0] p_ReqAddr,
  input  logic [DATA_W-1:0] p_ReqData,
  output logic              p_RspValid,
  output logic [DATA_W-1:0] p_RspData,
  output logic              p_Busy,
  output logic              p_MemEnable,
  output logic [ADDR_W-1:0] p_MemAddr,
  output logic [DATA_W-1:0] p_MemIn,
  input  logic [DATA_W-1:0] p_MemOutput
);
  state_t state, state_n;
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
`endif
  always_comb begin
    state_n = state;
    p_ReqReady = state == IDLE;
    p_RspValid = state == RESP;
    p_Busy = state != IDLE;
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
    p_MemEnable = state == WRITE || state == CLEAR;
`else
    p_MemEnable = state == WRITE;
`endif
    case (state)
      IDLE: state_n = p_ReqValid ? (p_ReqWrite == OP_WRITE ? WRITE : READ) : IDLE;
      WRITE: state_n = RESP;
      READ: state_n = CAPTURE;
      CAPTURE: state_n = RESP;
      RESP: state_n = IDLE;
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
      CLEAR: state_n = p_MemAddr == LAST ? IDLE : CLEAR;
`endif
      default: state_n = IDLE;
    endcase
  end
  // p_MemAddr/p_MemIn double as the latched request and, in CLEAR, the fill counter
  always_ff @(posedge p_Clock) begin
    if (!p_Resetn) begin
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
      p_RspData <= '0;
      p_MemAddr <= '0;
      p_MemIn <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && p_ReqValid) begin
        p_MemAddr <= ADDR_W'(32'(p_ReqAddr) % DEPTH);
        if (p_ReqWrite == OP_WRITE) p_MemIn <= p_ReqData;
      end
      if (state == WRITE) p_RspData <= p_MemIn;
      if (state == CAPTURE) p_RspData <= p_MemOutput;
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
      if (state == CLEAR && p_MemAddr != LAST) p_MemAddr <= p_MemAddr + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: scoreboard bench for mem_controller with an attached 32x16 registered-read memory
module tb_mem_controller;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int DEPTH = 32;
  typedef struct {
    logic [DW-1:0] d;
    int due;
  } exp_t;
  logic p_Clock, p_Resetn, p_ReqValid, p_ReqReady, p_ReqWrite, p_RspValid, p_Busy, p_MemEnable;
  logic [AW-1:0] p_ReqAddr, p_MemAddr;
  logic [DW-1:0] p_ReqData, p_RspData, p_MemIn, p_MemOutput;
  logic [DW-1:0] mem[DEPTH];
  logic [DW-1:0] shadow[DEPTH];
  logic [DW-1:0] last_rsp, exp_data;
  logic [AW-1:0] exp_addr;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, last_acc = 0, rsp_seen = 0;
  bit wr_next = 0, rd_next = 0, armed = 0, clearing = 0;

  mem_controller #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .p_Clock(p_Clock), .p_Resetn(p_Resetn), .p_ReqValid(p_ReqValid), .p_ReqReady(p_ReqReady),
    .p_ReqWrite(p_ReqWrite), .p_ReqAddr(p_ReqAddr), .p_ReqData(p_ReqData), .p_RspValid(p_RspValid),
    .p_RspData(p_RspData), .p_Busy(p_Busy), .p_MemEnable(p_MemEnable), .p_MemAddr(p_MemAddr),
    .p_MemIn(p_MemIn), .p_MemOutput(p_MemOutput)
  );

  initial begin
    p_Clock = 0;
    forever #5 p_Clock = ~p_Clock;
  end

  always @(posedge p_Clock) begin
    if (p_MemEnable) mem[p_MemAddr] <= p_MemIn;
    else p_MemOutput <= mem[p_MemAddr];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // expected response and its due cycle are queued at the accept edge
  always @(posedge p_Clock) begin
    cyc++;
    wr_next = 0;
    rd_next = 0;
    if (p_Resetn && p_ReqValid && p_ReqReady) begin
      last_acc = cyc;
      exp_addr = p_ReqAddr;
      exp_data = p_ReqData;
      if (p_ReqWrite) begin
        shadow[p_ReqAddr] = p_ReqData;
        q.push_back('{p_ReqData, cyc + 1});
        wr_next = 1;
      end else begin
        q.push_back('{shadow[p_ReqAddr], cyc + 2});
        rd_next = 1;
      end
    end
  end

  always @(negedge p_Clock) begin
    if (armed && p_Resetn) begin
      if (!clearing && (p_MemEnable || wr_next)) chk("mem_enable", p_MemEnable, wr_next);
      if (wr_next) begin
        chk("write_addr", p_MemAddr, exp_addr);
        chk("write_data", p_MemIn, exp_data);
      end
      if (rd_next) chk("read_addr", p_MemAddr, exp_addr);
      if (p_RspValid) begin
        rsp_seen++;
        if (q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          chk("rsp_data", p_RspData, q[0].d);
          chk("rsp_cycle", cyc, q[0].due);
          void'(q.pop_front());
        end
        last_rsp = p_RspData;
      end else begin
        if (!clearing) chk("rsp_hold", p_RspData, last_rsp);
        if (q.size() != 0 && cyc > q[0].due) begin
          chk("missing_rsp", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    int cnt;
    @(negedge p_Clock);
    p_Resetn = 0;
    p_ReqValid = 0;
    q.delete();
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
    clearing = 1;
`endif
    @(posedge p_Clock);
    #1;
    chk("rst_rsp_valid", p_RspValid, 0);
    chk("rst_rsp_data", p_RspData, 0);
    chk("rst_mem_addr", p_MemAddr, 0);
    chk("rst_mem_in", p_MemIn, 0);
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
    chk("rst_busy", p_Busy, 1);
    chk("rst_mem_enable", p_MemEnable, 1);
    chk("rst_ready", p_ReqReady, 0);
`else
    chk("rst_busy", p_Busy, 0);
    chk("rst_mem_enable", p_MemEnable, 0);
    chk("rst_ready", p_ReqReady, 1);
`endif
    last_rsp = 0;
    @(negedge p_Clock);
    p_Resetn = 1;
`ifdef MEM_CONTROLLER_INIT_CLEAR_EN
    cnt = 0;
    while (!p_ReqReady && cnt < 100) begin
      chk("clear_enable", p_MemEnable, 1);
      chk("clear_addr", p_MemAddr, cnt);
      chk("clear_data", p_MemIn, 0);
      cnt++;
      @(negedge p_Clock);
    end
    chk("clear_cycles", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    clearing = 0;
`else
    cnt = 0;
    chk("clear_cycles", cnt, 0);
`endif
    armed = 1;
  endtask

  task automatic req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int i;
    @(negedge p_Clock);
    p_ReqValid = 1;
    p_ReqWrite = w;
    p_ReqAddr = a;
    p_ReqData = d;
    for (i = 0; i < 50 && !p_ReqReady; i++) @(negedge p_Clock);
    if (!p_ReqReady) begin
      chk("accept_timeout", 0, 1);
      p_ReqValid = 0;
    end else begin
      @(posedge p_Clock);
      #1;
    end
  endtask

  task automatic idle();
    @(negedge p_Clock);
    p_ReqValid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge p_Clock);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge p_Clock);
  endtask

  initial begin
    int a0, r0;
    p_Resetn = 1;
    p_ReqValid = 0;
    p_ReqWrite = 0;
    p_ReqAddr = '0;
    p_ReqData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    do_reset();
    req(1, 5, 16'hBEEF); idle(); drain();
    req(0, 5, 16'h0000); idle(); drain();
    req(1, 31, 16'h1234); idle();
    req(1, 0, 16'h5678); idle();
    req(0, 31, 16'h0000); idle();
    req(0, 0, 16'h0000); idle(); drain();
    req(1, 10, 16'hA5A5); idle();
    req(1, 10, 16'h0F0F); idle();
    req(0, 10, 16'h0000); idle(); drain();
    r0 = rsp_seen;
    req(0, 5, 16'h0); a0 = last_acc;
    req(0, 31, 16'h0); chk("b2b_gap1", last_acc - a0, 4); a0 = last_acc;
    req(0, 0, 16'h0); chk("b2b_gap2", last_acc - a0, 4);
    idle(); drain();
    chk("b2b_rsp_count", rsp_seen - r0, 3);
    req(0, 31, 16'h0);
    @(negedge p_Clock);
    p_ReqValid = 0;
    r0 = rsp_seen;
    do_reset();
    repeat (4) @(negedge p_Clock);
    chk("abort_no_rsp", rsp_seen - r0, 0);
    req(0, 31, 16'h0); idle(); drain();
    req(1, 17, 16'hFFFF); idle(); drain();
    do_reset();
    req(0, 17, 16'h0); idle(); drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
